// File: rtl/operand_accumulator_if.sv
// ----------------------------------------------------------------------------
// operand_accumulator_if
//   Operand stream in, group result out, plus the busy indication.
//   slave  : the accumulator side (accepts operands, presents results)
//   master : the producer/consumer side that drives operands and takes results
// ----------------------------------------------------------------------------
interface operand_accumulator_if #(
    parameter int SIZE = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] out_sum;
    logic            out_ovf;
    logic            busy;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, busy
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, busy
    );
endinterface

// File: rtl/operand_accumulator.sv
// ----------------------------------------------------------------------------
// operand_accumulator
//   Sums each group of NUM_OPS unsigned SIZE-bit operands received over a
//   valid/ready stream through one ripple_carry adder (acc on A, operand on B,
//   carry-in 0) and presents the group total with a sticky overflow flag.
//
//   Optional feature macro: ACC_SAT_EN
//     defined   : any adder carry saturates the accumulator to all ones
//     undefined : the accumulator wraps modulo 2^SIZE
//   Overflow flag, handshake timing and latency are the same in both builds.
//
//   Reset is synchronous and active low.
// ----------------------------------------------------------------------------

// ripple_carry: SIZE-bit ripple adder exposing the carry out of every stage.
module ripple_carry #(
    parameter int SIZE = 4
) (
    input  logic [SIZE-1:0] A,
    input  logic [SIZE-1:0] B,
    input  logic            Cin,
    output logic [SIZE-1:0] S,
    output logic [SIZE-1:0] Cout
);
    // Walk the carry from bit 0 upward, one full adder per bit.
    always_comb begin
        logic c;
        // NOTE: every output bit is assigned on every pass through this block,
        // so no storage is implied.
        c = Cin;
        for (int i = 0; i < SIZE; i++) begin
            S[i]    = A[i] ^ B[i] ^ c;
            c       = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
            Cout[i] = c;
        end
    end
endmodule

module operand_accumulator #(
    parameter int SIZE    = 4,
    parameter int NUM_OPS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    operand_accumulator_if.slave bus
);
    localparam int              CNT_W    = $clog2(NUM_OPS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_OPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t           state;
    logic [SIZE-1:0]  acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [SIZE-1:0]  sum;
    logic [SIZE-1:0]  carries;
    logic             carry;
    logic [SIZE-1:0]  acc_upd;
    logic             ovf_upd;
    logic             in_take;
    logic             out_take;

    ripple_carry #(
        .SIZE (SIZE)
    ) u_adder (
        .A    (acc),
        .B    (bus.in_data),
        .Cin  (1'b0),
        .S    (sum),
        .Cout (carries)
    );

    // Only the top-stage carry signals overflow; the lower stage carries are
    // internal to the chain and deliberately left unobserved.
    assign carry = carries[SIZE-1];
    logic unused_carry_chain;
    assign unused_carry_chain = ^carries;

`ifdef ACC_SAT_EN
    // Saturate on carry; an all-ones accumulator can only stay all ones.
    assign acc_upd = carry ? {SIZE{1'b1}} : sum;
`else
    // Wrap modulo 2^SIZE.
    assign acc_upd = sum;
`endif
    assign ovf_upd = ovf | carry;

    assign in_take  = bus.in_valid  & in_ready_q;
    assign out_take = out_valid_q   & bus.out_ready;

    // Group sequencing: operand acceptance, accumulation and result hand-off.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register sees the pre-edge values of the others.
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_take) begin
                        // acc is 0 here, so the adder result is just the operand.
                        acc    <= bus.in_data;
                        cnt    <= CNT_W'(1);
                        ovf    <= 1'b0;
                        busy_q <= 1'b1;
                        if (NUM_OPS == 1) begin
                            state       <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (in_take) begin
                        acc <= acc_upd;
                        ovf <= ovf_upd;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST_CNT) begin
                            state       <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_take) begin
                        state       <= IDLE;
                        acc         <= '0;
                        cnt         <= '0;
                        ovf         <= 1'b0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    acc         <= '0;
                    cnt         <= '0;
                    ovf         <= 1'b0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // acc and ovf are frozen in DONE, so they drive the result directly.
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = acc;
    assign bus.out_ovf   = ovf;
    assign bus.busy      = busy_q;
endmodule
